// File: rtl/rps_game_ctrl.sv
// Rock-paper-scissors match controller: debounces the raw player/host keys and
// drives the registered display-side interface (choices, ready/start levels, grades).
module rps_game_ctrl #(
  parameter int unsigned DEB_CYCLES    = 1_000_000,
  parameter int unsigned REVEAL_CYCLES = 50_000_000,
  parameter int unsigned WIN_SCORE     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] key_left,
  input  logic [2:0] key_right,
  input  logic       key_ready,
  input  logic       key_start,
  output logic [2:0] new_button_left,
  output logic [2:0] new_button_right,
  output logic       ready_pulse,
  output logic       start_pulse,
  output logic [2:0] grade_left,
  output logic [2:0] grade_right
);

  localparam int unsigned DW = $clog2(DEB_CYCLES + 1);
  localparam int unsigned RW = $clog2(REVEAL_CYCLES + 1);
  localparam logic [2:0]  WIN = 3'(WIN_SCORE);

  typedef enum logic [2:0] {IDLE, READY, PLAY, REVEAL, OVER} state_t;

  logic [7:0]    raw;
  logic [7:0]    sync1_q, sync2_q, deb_q, prev_q;
  logic [DW-1:0] cnt_q [8];

  assign raw = {key_start, key_ready, key_right, key_left};

  // Each bit flips only after DEB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      prev_q  <= '0;
      for (int unsigned i = 0; i < 8; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      prev_q  <= deb_q;
      for (int unsigned i = 0; i < 8; i++) begin
        if (sync2_q[i] != deb_q[i]) begin
          if (cnt_q[i] == DW'(DEB_CYCLES - 1)) begin
            deb_q[i] <= sync2_q[i];
            cnt_q[i] <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + 1'b1;
          end
        end else begin
          cnt_q[i] <= '0;
        end
      end
    end
  end

  logic [7:0] rise;
  logic       left_valid, right_valid, ready_ev, start_ev;

  assign rise        = deb_q & ~prev_q;
  assign left_valid  = (|rise[2:0]) && $onehot(deb_q[2:0]);
  assign right_valid = (|rise[5:3]) && $onehot(deb_q[5:3]);
  assign ready_ev    = rise[6];
  assign start_ev    = rise[7];

  function automatic logic beats(input logic [2:0] a, input logic [2:0] b);
    return (a == 3'b001 && b == 3'b010) ||
           (a == 3'b010 && b == 3'b100) ||
           (a == 3'b100 && b == 3'b001);
  endfunction

  state_t        state_q;
  logic [2:0]    lat_l_q, lat_r_q;
  logic          lat_l_v_q, lat_r_v_q;
  logic [RW-1:0] rev_cnt_q;
  logic [2:0]    choice_l_d, choice_r_d;
  logic          lat_l_v_d, lat_r_v_d;

  // A choice latched earlier in the round takes priority over a fresh press.
  always_comb begin
    choice_l_d = lat_l_v_q ? lat_l_q : deb_q[2:0];
    choice_r_d = lat_r_v_q ? lat_r_q : deb_q[5:3];
    lat_l_v_d  = lat_l_v_q | left_valid;
    lat_r_v_d  = lat_r_v_q | right_valid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      lat_l_q          <= '0;
      lat_r_q          <= '0;
      lat_l_v_q        <= 1'b0;
      lat_r_v_q        <= 1'b0;
      rev_cnt_q        <= '0;
      new_button_left  <= '0;
      new_button_right <= '0;
      ready_pulse      <= 1'b0;
      start_pulse      <= 1'b0;
      grade_left       <= '0;
      grade_right      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ready_ev) begin
            state_q     <= READY;
            ready_pulse <= 1'b1;
          end
        end
        READY: begin
          if (start_ev) begin
            state_q     <= PLAY;
            start_pulse <= 1'b1;
          end
        end
        PLAY: begin
          if (left_valid && !lat_l_v_q) begin
            lat_l_q   <= deb_q[2:0];
            lat_l_v_q <= 1'b1;
          end
          if (right_valid && !lat_r_v_q) begin
            lat_r_q   <= deb_q[5:3];
            lat_r_v_q <= 1'b1;
          end
          if (lat_l_v_d && lat_r_v_d) begin
            state_q          <= REVEAL;
            rev_cnt_q        <= '0;
            new_button_left  <= choice_l_d;
            new_button_right <= choice_r_d;
            if (beats(choice_l_d, choice_r_d))      grade_left  <= grade_left + 3'd1;
            else if (beats(choice_r_d, choice_l_d)) grade_right <= grade_right + 3'd1;
          end
        end
        REVEAL: begin
          if (rev_cnt_q == RW'(REVEAL_CYCLES - 1)) begin
            lat_l_q          <= '0;
            lat_r_q          <= '0;
            lat_l_v_q        <= 1'b0;
            lat_r_v_q        <= 1'b0;
            new_button_left  <= '0;
            new_button_right <= '0;
            if (grade_left == WIN || grade_right == WIN) begin
              state_q     <= OVER;
              ready_pulse <= 1'b0;
              start_pulse <= 1'b0;
            end else begin
              state_q <= PLAY;
            end
          end else begin
            rev_cnt_q <= rev_cnt_q + 1'b1;
          end
        end
        OVER: begin
          if (ready_ev) begin
            state_q     <= READY;
            ready_pulse <= 1'b1;
            grade_left  <= '0;
            grade_right <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rps_game_ctrl.sv
// Directed bench for rps_game_ctrl: expected reveal results are queued when the
// keys are driven and compared when the controller shows the round.
module tb_rps_game_ctrl;

  localparam int unsigned DEB = 4;
  localparam int unsigned REV = 8;
  localparam int unsigned WIN = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] key_left, key_right;
  logic       key_ready, key_start;
  logic [2:0] new_button_left, new_button_right;
  logic       ready_pulse, start_pulse;
  logic [2:0] grade_left, grade_right;

  rps_game_ctrl #(.DEB_CYCLES(DEB), .REVEAL_CYCLES(REV), .WIN_SCORE(WIN)) dut (
    .clk(clk), .rst(rst),
    .key_left(key_left), .key_right(key_right),
    .key_ready(key_ready), .key_start(key_start),
    .new_button_left(new_button_left), .new_button_right(new_button_right),
    .ready_pulse(ready_pulse), .start_pulse(start_pulse),
    .grade_left(grade_left), .grade_right(grade_right)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] l, r, gl, gr;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [2:0] l, input logic [2:0] r,
                      input logic [2:0] gl, input logic [2:0] gr);
    exp_t e;
    e.l = l; e.r = r; e.gl = gl; e.gr = gr;
    sb.push_back(e);
  endtask

  task automatic pop(output exp_t e);
    if (sb.size() > 0) e = sb.pop_front();
    else begin
      e.l = '0; e.r = '0; e.gl = '0; e.gr = '0;
    end
  endtask

  task automatic release_keys();
    key_left = '0; key_right = '0; key_ready = 1'b0; key_start = 1'b0;
    tick(12);
  endtask

  task automatic host_key(input logic is_ready);
    if (is_ready) key_ready = 1'b1; else key_start = 1'b1;
    tick(10);
    release_keys();
  endtask

  // Waits for a round to be shown, checks it against the queue head and its length.
  task automatic wait_reveal(input string tag);
    exp_t e;
    int   n = 0;
    int   len = 0;
    while (new_button_left == 3'b000 && new_button_right == 3'b000 && n < 40) begin
      @(negedge clk);
      n++;
    end
    pop(e);
    chk({tag, "_seen"}, 32'(n < 40), 32'd1);
    chk({tag, "_nbl"}, new_button_left, e.l);
    chk({tag, "_nbr"}, new_button_right, e.r);
    chk({tag, "_gl"}, grade_left, e.gl);
    chk({tag, "_gr"}, grade_right, e.gr);
    while ((new_button_left != 3'b000 || new_button_right != 3'b000) && len < 40) begin
      @(negedge clk);
      len++;
    end
    chk({tag, "_len"}, len, REV);
    chk({tag, "_gl_after"}, grade_left, e.gl);
    chk({tag, "_gr_after"}, grade_right, e.gr);
  endtask

  task automatic no_reveal(input string tag, input int n);
    logic seen = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (new_button_left != 3'b000 || new_button_right != 3'b000) seen = 1'b1;
    end
    chk(tag, seen, 1'b0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   n;
    rst = 1'b1;
    key_left = '0; key_right = '0; key_ready = 1'b0; key_start = 1'b0;
    tick(3);
    chk("rst_nbl", new_button_left, 3'b000);
    chk("rst_nbr", new_button_right, 3'b000);
    chk("rst_ready", ready_pulse, 1'b0);
    chk("rst_start", start_pulse, 1'b0);
    chk("rst_gl", grade_left, 3'b000);
    chk("rst_gr", grade_right, 3'b000);
    rst = 1'b0;
    tick(2);

    // 2 sync stages + DEB samples + registered output
    key_ready = 1'b1;
    n = 0;
    while (!ready_pulse && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_latency", n, 7);
    tick(3);
    release_keys();
    chk("ready_level", ready_pulse, 1'b1);
    chk("ready_start0", start_pulse, 1'b0);
    host_key(1'b0);
    chk("play_start", start_pulse, 1'b1);
    chk("play_ready", ready_pulse, 1'b1);
    chk("play_nbl", new_button_left, 3'b000);

    push(3'b001, 3'b010, 3'd1, 3'd0);
    key_left = 3'b001; key_right = 3'b010;
    wait_reveal("r1");
    release_keys();

    push(3'b100, 3'b100, 3'd1, 3'd0);
    key_left = 3'b100; key_right = 3'b100;
    wait_reveal("tie");
    release_keys();

    key_left = 3'b011;
    tick(12);
    key_left = 3'b000;
    tick(12);
    key_right = 3'b100;
    no_reveal("invalid_no_latch", 20);
    push(3'b010, 3'b100, 3'd2, 3'd0);
    key_left = 3'b010;
    wait_reveal("after_invalid");
    release_keys();

    for (int k = 1; k <= 3; k++) begin
      push(3'b001, 3'b100, 3'd2, 3'(k));
      key_left = 3'b001; key_right = 3'b100;
      wait_reveal($sformatf("rwin%0d", k));
      release_keys();
    end
    chk("over_ready", ready_pulse, 1'b0);
    chk("over_start", start_pulse, 1'b0);
    chk("over_gr", grade_right, 3'd3);
    key_left = 3'b010; key_right = 3'b001;
    no_reveal("over_keys_ignored", 20);
    release_keys();
    chk("over_gl_held", grade_left, 3'd2);
    chk("over_gr_held", grade_right, 3'd3);
    host_key(1'b1);
    chk("rematch_ready", ready_pulse, 1'b1);
    chk("rematch_gl", grade_left, 3'd0);
    chk("rematch_gr", grade_right, 3'd0);
    host_key(1'b0);
    chk("rematch_start", start_pulse, 1'b1);

    // Toggle period is shorter than the debounce window
    for (int k = 0; k < 20; k++) begin
      key_left = key_left ^ 3'b001;
      tick(2);
    end
    key_left = 3'b000;
    tick(12);
    key_right = 3'b010;
    no_reveal("bounce_no_latch", 20);
    push(3'b001, 3'b010, 3'd1, 3'd0);
    key_left = 3'b001;
    wait_reveal("after_bounce");
    release_keys();

    push(3'b100, 3'b001, 3'd2, 3'd0);
    key_left = 3'b100; key_right = 3'b001;
    wait_reveal("same_cycle");
    release_keys();

    push(3'b001, 3'b001, 3'd2, 3'd0);
    key_left = 3'b001; key_right = 3'b001;
    n = 0;
    while (new_button_left == 3'b000 && n < 40) begin
      @(negedge clk);
      n++;
    end
    pop(e);
    chk("pre_rst_nbl", new_button_left, e.l);
    chk("pre_rst_gl", grade_left, e.gl);
    tick(3);
    rst = 1'b1;
    #1;
    chk("async_nbl", new_button_left, 3'b000);
    chk("async_nbr", new_button_right, 3'b000);
    chk("async_ready", ready_pulse, 1'b0);
    chk("async_start", start_pulse, 1'b0);
    chk("async_gl", grade_left, 3'b000);
    chk("async_gr", grade_right, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    release_keys();
    host_key(1'b0);
    chk("idle_start_ignored", start_pulse, 1'b0);
    chk("idle_ready0", ready_pulse, 1'b0);
    host_key(1'b1);
    chk("idle_to_ready", ready_pulse, 1'b1);
    chk("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rps_game_ctrl.md
Name: rps_game_ctrl

Overview:
Game controller that sits upstream of the LED-matrix display block. It conditions the raw player and host keys and runs the rock-paper-scissors match. It produces the display-side interface: new_button_left/right, ready_pulse, start_pulse and grade_left/right. It is the producer end of the interface that the display block consumes.

Parameters:
DEB_CYCLES, 1_000_000, consecutive stable clk samples required to accept a key level (20 ms at 50 MHz).
REVEAL_CYCLES, 50_000_000, clk cycles that both choices stay shown after a round resolves.
WIN_SCORE, 3, grade value that ends the match (1..7).

Ports:
clk  input  1  system clock, 50 MHz
rst  input  1  asynchronous, active-high reset
key_left  input  3  raw left-player keys, active-high: bit0 rock, bit1 scissors, bit2 paper
key_right  input  3  raw right-player keys, same encoding
key_ready  input  1  raw host "ready" key, active-high
key_start  input  1  raw host "start" key, active-high
new_button_left  output  3  left choice shown to display, one-hot or 000
new_button_right  output  3  right choice shown to display, one-hot or 000
ready_pulse  output  1  level, high in READY/PLAY/REVEAL
start_pulse  output  1  level, high in PLAY/REVEAL
grade_left  output  3  left score
grade_right  output  3  right score

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; debouncers cleared to 0; latched choices cleared.
- Key conditioning (all 8 raw bits): 2-FF synchronizer, then a per-bit counter.
  - The debounced level changes only after DEB_CYCLES consecutive samples differ from the current level.
  - A 0->1 transition of the debounced level gives a 1-cycle internal press event.
  - A player press is valid only if exactly one bit of that player's 3-bit debounced vector is high in the press cycle. Otherwise the press is ignored.
- FSM:
  - IDLE: all outputs 0. ready press -> READY.
  - READY: ready_pulse=1. start press -> PLAY. Player presses are ignored.
  - PLAY: ready_pulse=1, start_pulse=1, new_button_*=000.
    - The first valid press per player is latched. Later presses by the same player are ignored until the round ends.
    - When both choices are latched (including a same-cycle latch of both) -> REVEAL next cycle.
  - REVEAL: new_button_* drive the latched choices.
    - On the entry cycle, scores update exactly once:
      - rock beats scissors, scissors beats paper, paper beats rock;
      - the winner's grade +1; a tie changes nothing.
    - After REVEAL_CYCLES cycles: latches are cleared, new_button_* = 000, then -> OVER if either grade == WIN_SCORE, else -> PLAY.
  - OVER: ready_pulse=0, start_pulse=0, new_button_*=000, grades held. ready press -> READY with both grades cleared on the same edge.
- Timing: outputs are registered. grade_* change on the cycle new_button_* first becomes non-zero.
- Grades never exceed WIN_SCORE (the match ends on reaching it).
- start press outside READY, and ready press outside IDLE/OVER, are ignored.
- rst asserted mid-round: everything returns to IDLE immediately. No partial score is retained.
- Key bounce shorter than DEB_CYCLES produces no event. A key held continuously produces exactly one event.

Test Plan:
Use DEB_CYCLES=4, REVEAL_CYCLES=8, WIN_SCORE=3 for all scenarios.
1. Reset, then pulse key_ready for 10 cycles -> ready_pulse=1 about 7 cycles later, start_pulse=0, grades 000. Then key_start for 10 cycles -> start_pulse=1.
2. In PLAY: left 001, right 010 -> new_button_left=001, new_button_right=010 for 8 cycles, grade_left=001, grade_right=000; afterwards both new_button = 000.
3. Tie 100/100, then left 011 (invalid) followed by valid 010 vs right 100 -> first round grades unchanged; second round grade_left +1. The invalid press produces no latch.
4. Right wins three rounds (right 100 vs left 001, each) -> grade_right=011, state OVER, ready_pulse=0, start_pulse=0. Further player keys have no effect. key_ready -> grades 000, ready_pulse=1.
5. key_left toggling every 2 cycles for 40 cycles -> no latch, new_button_left stays 000. Both players pressing on the same cycle -> REVEAL the next cycle with a single score update.
6. Assert rst during REVEAL -> all outputs 0 asynchronously, before the next clk edge. After release, state is IDLE.
